// File: rtl/riscv_datapath.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback all complete in one clk.
// No external bus and no stalls. The ROM image is the IMEM_IMAGE parameter (word i at bits [32*i +: 32]).
module riscv_datapath #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter logic [32*IMEM_WORDS-1:0] IMEM_IMAGE = {{(IMEM_WORDS-4){32'h00000013}},
                                                    32'h00418663, 32'h00012283,
                                                    32'h00112023, 32'h003100B3}
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rf_q [32];
  logic [31:0]   dmem_q [DMEM_WORDS];

  logic [IW-1:0] imem_idx;
  logic [31:0]   instr;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   rs1_val, rs2_val;
  logic [31:0]   imm_i, imm_s, imm_b, imm_j, imm_u;

  alu_op_e       alu_op;
  wb_sel_e       wb_sel;
  logic [31:0]   alu_b, alu_res;
  logic          rf_we, dmem_we, br_taken, jump;
  logic [DW-1:0] dmem_idx;
  logic [31:0]   mem_rdat, rf_wdat, pc_plus4;

  // Addresses past the ROM fetch a NOP so the core free-runs through empty space.
  always_comb begin
    imem_idx = pc_q[2 +: IW];
    instr    = NOP;
    if (pc_q[31:2] < 30'(IMEM_WORDS)) begin
      instr = IMEM_IMAGE[32*imem_idx +: 32];
    end
  end

  always_comb begin
    opcode  = instr[6:0];
    rd      = instr[11:7];
    funct3  = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    funct7  = instr[31:25];
    rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    imm_i   = {{20{instr[31]}}, instr[31:20]};
    imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    imm_u   = {instr[31:12], 12'd0};
  end

  // Unsupported encodings leave every enable low, which makes them behave as NOPs.
  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = imm_i;
    wb_sel   = WB_ALU;
    rf_we    = 1'b0;
    dmem_we  = 1'b0;
    br_taken = 1'b0;
    jump     = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        alu_b = rs2_val;
        if (funct7 == 7'b0000000) begin
          rf_we = 1'b1;
          unique case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          rf_we  = 1'b1;
          alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          rf_we  = 1'b1;
          alu_op = ALU_SRA;
        end
      end
      7'b0010011: begin
        unique case (funct3)
          3'b000:  begin rf_we = 1'b1; alu_op = ALU_ADD; end
          3'b010:  begin rf_we = 1'b1; alu_op = ALU_SLT; end
          3'b100:  begin rf_we = 1'b1; alu_op = ALU_XOR; end
          3'b110:  begin rf_we = 1'b1; alu_op = ALU_OR;  end
          3'b111:  begin rf_we = 1'b1; alu_op = ALU_AND; end
          default: ;
        endcase
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          rf_we  = 1'b1;
          wb_sel = WB_MEM;
        end
      end
      7'b0100011: begin
        alu_b = imm_s;
        if (funct3 == 3'b010) dmem_we = 1'b1;
      end
      7'b1100011: begin
        if (funct3 == 3'b000)      br_taken = (rs1_val == rs2_val);
        else if (funct3 == 3'b001) br_taken = (rs1_val != rs2_val);
      end
      7'b1101111: begin
        rf_we  = 1'b1;
        wb_sel = WB_PC4;
        jump   = 1'b1;
      end
      7'b0110111: begin
        rf_we  = 1'b1;
        wb_sel = WB_IMM;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = rs1_val + alu_b;
    unique case (alu_op)
      ALU_ADD:  alu_res = rs1_val + alu_b;
      ALU_SUB:  alu_res = rs1_val - alu_b;
      ALU_AND:  alu_res = rs1_val & alu_b;
      ALU_OR:   alu_res = rs1_val | alu_b;
      ALU_XOR:  alu_res = rs1_val ^ alu_b;
      ALU_SLT:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, rs1_val < alu_b};
      ALU_SLL:  alu_res = rs1_val << alu_b[4:0];
      ALU_SRL:  alu_res = rs1_val >> alu_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
      default:  alu_res = rs1_val + alu_b;
    endcase
  end

  // Byte offset within the word is dropped; the word address folds onto the RAM depth.
  always_comb begin
    dmem_idx = DW'(alu_res[31:2] % DMEM_WORDS);
    mem_rdat = dmem_q[dmem_idx];
    pc_plus4 = pc_q + 32'd4;
    unique case (wb_sel)
      WB_ALU:  rf_wdat = alu_res;
      WB_MEM:  rf_wdat = mem_rdat;
      WB_PC4:  rf_wdat = pc_plus4;
      default: rf_wdat = imm_u;
    endcase
    if (jump)          pc_d = pc_q + imm_j;
    else if (br_taken) pc_d = pc_q + imm_b;
    else               pc_d = pc_plus4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 32'd0;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'(4 * i);
    end else if (rf_we && rd != 5'd0) begin
      rf_q[rd] <= rf_wdat;
    end
  end

  // Data RAM keeps its contents across reset; stores are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (dmem_we && reset) dmem_q[dmem_idx] <= rs2_val;
  end

endmodule

// File: tb/tb_riscv_datapath.sv
// Directed bench: default image on dut_a (program flow, resets, ROM overrun); a second image on dut_b
// exercising taken branches, x0 writes, ALU ops, lw/sw address folding and jal both directions.
module tb_riscv_datapath;

  localparam logic [32*64-1:0] PROG_B = {
    {47{32'h00000013}},
    32'hFC1FF8EF,  // 16 jal  x17,-64
    32'h00100813,  // 15 addi x16,x0,1 (skipped)
    32'h008007EF,  // 14 jal  x15,8
    32'h00109463,  // 13 bne  x1,x1,8
    32'h10002703,  // 12 lw   x14,256(x0)
    32'hFE20AE23,  // 11 sw   x2,-4(x1)
    32'hFFF14693,  // 10 xori x13,x2,-1
    32'hABCDE637,  //  9 lui  x12,0xABCDE
    32'h0023B5B3,  //  8 sltu x11,x7,x2
    32'h0023A533,  //  7 slt  x10,x7,x2
    32'h0013D4B3,  //  6 srl  x9,x7,x1
    32'h4013D433,  //  5 sra  x8,x7,x1
    32'h403103B3,  //  4 sub  x7,x2,x3
    32'h00500013,  //  3 addi x0,x0,5
    32'h00100313,  //  2 addi x6,x0,1 (skipped)
    32'h00100313,  //  1 addi x6,x0,1 (skipped)
    32'h00210663   //  0 beq  x2,x2,12
  };

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  riscv_datapath dut_a (.clk(clk), .reset(rst_a));
  riscv_datapath #(.IMEM_IMAGE(PROG_B)) dut_b (.clk(clk), .reset(rst_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_a();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    #9;
    check("rst_pc",  dut_a.pc_q,     32'd0);
    check("rst_rf0", dut_a.rf_q[0],  32'd0);
    check("rst_rf2", dut_a.rf_q[2],  32'd8);
    check("rst_rf3", dut_a.rf_q[3],  32'd12);
    check("rst_rf4", dut_a.rf_q[4],  32'd16);
    check("rst_rf31", dut_a.rf_q[31], 32'd124);
    #1 rst_a = 1'b1;

    step_a();
    check("add_rf1", dut_a.rf_q[1], 32'd20);
    check("add_pc",  dut_a.pc_q,    32'd4);
    step_a();
    check("sw_dmem2", dut_a.dmem_q[2], 32'd20);
    check("sw_pc",    dut_a.pc_q,      32'd8);
    step_a();
    check("lw_rf5", dut_a.rf_q[5], 32'd20);
    check("lw_pc",  dut_a.pc_q,    32'd12);
    step_a();
    check("beq_nt_pc", dut_a.pc_q, 32'd16);
    repeat (3) @(posedge clk);
    #1;
    check("nop_pc",    dut_a.pc_q,      32'd28);
    check("nop_rf1",   dut_a.rf_q[1],   32'd20);
    check("nop_rf6",   dut_a.rf_q[6],   32'd24);
    check("nop_dmem2", dut_a.dmem_q[2], 32'd20);

    // Asynchronous reset in the middle of a run.
    rst_a = 1'b0;
    #1;
    check("mid_rst_pc",    dut_a.pc_q,      32'd0);
    check("mid_rst_rf1",   dut_a.rf_q[1],   32'd4);
    check("mid_rst_dmem2", dut_a.dmem_q[2], 32'd20);
    @(negedge clk) rst_a = 1'b1;
    step_a();
    check("restart_pc",  dut_a.pc_q,    32'd4);
    check("restart_rf1", dut_a.rf_q[1], 32'd20);
    step_a();
    check("restart_pc8", dut_a.pc_q, 32'd8);
    rst_a = 1'b0;
    #1;
    check("rst_at8_pc",    dut_a.pc_q,      32'd0);
    check("rst_at8_rf1",   dut_a.rf_q[1],   32'd4);
    check("rst_at8_dmem2", dut_a.dmem_q[2], 32'd20);
    @(negedge clk) rst_a = 1'b1;

    // Run past the end of the ROM: NOPs only, pc keeps stepping by 4.
    repeat (70) @(posedge clk);
    #1;
    check("overrun_pc",    dut_a.pc_q,      32'd280);
    check("overrun_rf1",   dut_a.rf_q[1],   32'd20);
    check("overrun_rf5",   dut_a.rf_q[5],   32'd20);
    check("overrun_dmem2", dut_a.dmem_q[2], 32'd20);

    @(negedge clk) rst_b = 1'b1;
    step_a();
    check("b_beq_taken_pc", dut_b.pc_q, 32'd12);
    step_a();
    check("b_x0_write", dut_b.rf_q[0], 32'd0);
    check("b_addi_pc",  dut_b.pc_q,    32'd16);
    step_a();
    check("b_sub", dut_b.rf_q[7], 32'hFFFF_FFFC);
    step_a();
    check("b_sra", dut_b.rf_q[8], 32'hFFFF_FFFF);
    step_a();
    check("b_srl", dut_b.rf_q[9], 32'h0FFF_FFFF);
    step_a();
    check("b_slt", dut_b.rf_q[10], 32'd1);
    step_a();
    check("b_sltu", dut_b.rf_q[11], 32'd0);
    step_a();
    check("b_lui", dut_b.rf_q[12], 32'hABCD_E000);
    step_a();
    check("b_xori", dut_b.rf_q[13], 32'hFFFF_FFF7);
    step_a();
    check("b_sw_neg_off", dut_b.dmem_q[0], 32'd8);
    step_a();
    check("b_lw_wrap", dut_b.rf_q[14], 32'd8);
    step_a();
    check("b_bne_nt_pc", dut_b.pc_q, 32'd56);
    step_a();
    check("b_jal_fwd_pc", dut_b.pc_q,     32'd64);
    check("b_jal_fwd_rd", dut_b.rf_q[15], 32'd60);
    step_a();
    check("b_jal_back_pc", dut_b.pc_q,     32'd0);
    check("b_jal_back_rd", dut_b.rf_q[17], 32'd68);
    check("b_skip_rf16",   dut_b.rf_q[16], 32'd64);
    check("b_skip_rf6",    dut_b.rf_q[6],  32'd24);
    step_a();
    check("b_loop_pc", dut_b.pc_q, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
